// File: rtl/morse_symbol_collector.sv
// Morse key front end: synchronizes and debounces the key, classifies dot/dash presses
// and commits characters after a gap. `MORSE_COLLECTOR_LIVE_EN enables live preview.
module morse_symbol_collector #(
  parameter int unsigned DEBOUNCE_TICKS = 500000,
  parameter int unsigned DASH_TICKS     = 15000000,
  parameter int unsigned GAP_TICKS      = 30000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [4:0] possible_chars,
  output logic [2:0] possible_inputs,
  output logic       char_valid,
  output logic       char_err,
  output logic       busy
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int unsigned LenW = $clog2(DASH_TICKS + 1);
  localparam int unsigned GapW = $clog2(GAP_TICKS + 1);

  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_TICKS - 1);
  localparam logic [LenW-1:0] DashMax = LenW'(DASH_TICKS);
  localparam logic [GapW-1:0] GapMax  = GapW'(GAP_TICKS);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  logic [1:0]      sync_q;
  logic            key_db_q, key_db_d;
  logic [DbW-1:0]  db_cnt_q, db_cnt_d;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [GapW-1:0] gap_q, gap_d, gap_inc;
  logic [4:0]      shreg_q, shreg_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [4:0]      chars_q, chars_d;
  logic [2:0]      inputs_q, inputs_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            classify;
  logic            sym;

  // Debounce: the count only survives while the synchronized key disagrees.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (sync_q[1] != key_db_q) begin
      if (db_cnt_q == DbLast) begin
        key_db_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign sym     = (len_q >= DashMax);
  assign gap_inc = gap_q + GapW'(1);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    chars_d  = chars_q;
    inputs_d = inputs_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    classify = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (key_db_q) begin
          state_d = StPress;
          len_d   = '0;
        end
      end
      StPress: begin
        if (!key_db_q) begin
          classify = 1'b1;
          state_d  = StGap;
          gap_d    = '0;
        end else if (len_q != DashMax) begin
          len_d = len_q + LenW'(1);
        end
      end
      StGap: begin
        // A new press wins over a commit landing on the same edge.
        if (key_db_q) begin
          state_d = StPress;
          len_d   = '0;
        end else if (gap_inc == GapMax) begin
          state_d  = StIdle;
          gap_d    = '0;
          valid_d  = 1'b1;
          err_d    = ovf_q;
          chars_d  = ovf_q ? 5'd0 : shreg_q;
          inputs_d = ovf_q ? 3'd0 : cnt_q;
          shreg_d  = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (classify) begin
      if (cnt_q < 3'd5) begin
        shreg_d[cnt_q] = sym;
        cnt_d          = cnt_q + 3'd1;
`ifdef MORSE_COLLECTOR_LIVE_EN
        chars_d  = shreg_d;
        inputs_d = cnt_d;
`endif
      end else begin
        ovf_d = 1'b1;
`ifdef MORSE_COLLECTOR_LIVE_EN
        chars_d  = 5'd0;
        inputs_d = 3'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      key_db_q <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= StIdle;
      len_q    <= '0;
      gap_q    <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      chars_q  <= '0;
      inputs_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_in};
      key_db_q <= key_db_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      chars_q  <= chars_d;
      inputs_q <= inputs_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign possible_chars  = chars_q;
  assign possible_inputs = inputs_q;
  assign char_valid      = valid_q;
  assign char_err        = err_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_morse_symbol_collector.sv
// Directed bench for morse_symbol_collector with small timing parameters.
module tb_morse_symbol_collector;

  logic       clk;
  logic       rst_n;
  logic       key_in;
  logic [4:0] possible_chars;
  logic [2:0] possible_inputs;
  logic       char_valid;
  logic       char_err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  int         valid_cnt = 0;
  int         err_cnt   = 0;
  logic [4:0] last_chars;
  logic [2:0] last_inputs;
  logic       last_err;

  morse_symbol_collector #(
    .DEBOUNCE_TICKS(4),
    .DASH_TICKS    (20),
    .GAP_TICKS     (40)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_in         (key_in),
    .possible_chars (possible_chars),
    .possible_inputs(possible_inputs),
    .char_valid     (char_valid),
    .char_err       (char_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each commit pulse as seen just after the edge.
  always @(posedge clk) begin
    #1;
    if (char_valid) begin
      valid_cnt   = valid_cnt + 1;
      last_chars  = possible_chars;
      last_inputs = possible_inputs;
      last_err    = char_err;
    end
    if (char_err) err_cnt = err_cnt + 1;
  end

  task automatic drive(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_commit(input string name, input int v0, input logic [4:0] ec,
                              input logic [2:0] ei, input logic ee);
    tests++;
    if (valid_cnt !== v0 + 1) begin
      fails++;
      $display("FAIL %s_valid: got %0d pulses want 1", name, valid_cnt - v0);
    end
    tests++;
    if (last_chars !== ec || possible_chars !== ec) begin
      fails++;
      $display("FAIL %s_chars: got %b/%b want %b", name, last_chars, possible_chars, ec);
    end
    tests++;
    if (last_inputs !== ei || possible_inputs !== ei) begin
      fails++;
      $display("FAIL %s_inputs: got %0d/%0d want %0d", name, last_inputs, possible_inputs, ei);
    end
    tests++;
    if (last_err !== ee) begin
      fails++;
      $display("FAIL %s_err: got %b want %b", name, last_err, ee);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    int v0;
    rst_n  = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({possible_chars, possible_inputs, char_valid, char_err, busy} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0",
               {possible_chars, possible_inputs, char_valid, char_err, busy});
    end
    rst_n = 1'b1;
    drive(1'b0, 5);
    v0 = valid_cnt;
    drive(1'b1, 3);
    drive(1'b0, 20);
    tests++;
    if (busy !== 1'b0 || valid_cnt !== v0) begin
      fails++;
      $display("FAIL glitch: got busy %b pulses %0d want 0 0", busy, valid_cnt - v0);
    end
  endtask

  task automatic test_letter_a;
    int v0 = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 15);
    drive(1'b1, 30);
    drive(1'b0, 60);
    check_commit("a", v0, 5'b00010, 3'd2, 1'b0);
  endtask

  task automatic test_digit_one;
    int v0 = valid_cnt;
    drive(1'b1, 10);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 15);
      drive(1'b1, 30);
    end
    drive(1'b0, 60);
    check_commit("one", v0, 5'b11110, 3'd5, 1'b0);
  endtask

  task automatic test_dash_boundary;
    int v0 = valid_cnt;
    drive(1'b1, 20);
    drive(1'b0, 15);
    drive(1'b1, 21);
    drive(1'b0, 60);
    check_commit("dash_edge", v0, 5'b00010, 3'd2, 1'b0);
  endtask

  task automatic test_gap_boundary;
    int v0 = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 40);
    drive(1'b1, 10);
    drive(1'b0, 60);
    check_commit("gap_edge", v0, 5'b00000, 3'd2, 1'b0);
  endtask

  task automatic test_overflow;
    int v0 = valid_cnt;
    int e0 = err_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 10);
      drive(1'b0, 15);
    end
    drive(1'b0, 45);
    check_commit("ovf", v0, 5'd0, 3'd0, 1'b1);
    tests++;
    if (err_cnt !== e0 + 1) begin
      fails++;
      $display("FAIL ovf_err_count: got %0d want 1", err_cnt - e0);
    end
    v0 = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 60);
    check_commit("e_after_ovf", v0, 5'd0, 3'd1, 1'b0);
  endtask

  task automatic test_hold;
    int v0 = valid_cnt;
    drive(1'b1, 120);
    tests++;
    if (busy !== 1'b1 || valid_cnt !== v0) begin
      fails++;
      $display("FAIL hold: got busy %b pulses %0d want 1 0", busy, valid_cnt - v0);
    end
    drive(1'b0, 60);
    check_commit("hold_t", v0, 5'b00001, 3'd1, 1'b0);
  endtask

  task automatic test_reset_mid_char;
    int v0 = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 15);
    drive(1'b1, 10);
    drive(1'b0, 15);
    rst_n = 1'b0;
    drive(1'b0, 3);
    rst_n = 1'b1;
    drive(1'b0, 60);
    tests++;
    if (possible_chars !== 5'd0 || possible_inputs !== 3'd0 || valid_cnt !== v0) begin
      fails++;
      $display("FAIL rst_mid: got %b/%0d pulses %0d want 0/0 0",
               possible_chars, possible_inputs, valid_cnt - v0);
    end
    drive(1'b1, 30);
    drive(1'b0, 60);
    check_commit("after_rst", v0, 5'b00001, 3'd1, 1'b0);
  endtask

  task automatic test_preview;
    int v0 = valid_cnt;
    logic [4:0] ec;
    logic [2:0] ei;
    drive(1'b1, 10);
    drive(1'b0, 15);
`ifdef MORSE_COLLECTOR_LIVE_EN
    ec = 5'b00000; ei = 3'd1;
`else
    ec = 5'b00001; ei = 3'd1;
`endif
    tests++;
    if (possible_chars !== ec || possible_inputs !== ei) begin
      fails++;
      $display("FAIL preview_1: got %b/%0d want %b/%0d", possible_chars, possible_inputs, ec, ei);
    end
    drive(1'b1, 30);
    drive(1'b0, 15);
`ifdef MORSE_COLLECTOR_LIVE_EN
    ec = 5'b00010; ei = 3'd2;
`else
    ec = 5'b00001; ei = 3'd1;
`endif
    tests++;
    if (possible_chars !== ec || possible_inputs !== ei) begin
      fails++;
      $display("FAIL preview_2: got %b/%0d want %b/%0d", possible_chars, possible_inputs, ec, ei);
    end
    drive(1'b0, 45);
    check_commit("preview_end", v0, 5'b00010, 3'd2, 1'b0);
  endtask

  initial begin
    test_reset;
    test_letter_a;
    test_digit_one;
    test_dash_boundary;
    test_gap_boundary;
    test_overflow;
    test_hold;
    test_reset_mid_char;
    test_preview;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
